// File: rtl/r5p_degu_ifq.sv
// r5p_degu_ifq: instruction fetch queue between the TCB instruction bus and
// the Degu decode stage.
//
// Fetches word-aligned 32-bit words into a small FIFO and extracts
// instructions from the head of that FIFO. A redirect flushes the queue and
// restarts fetching at the new address.
//
// Optional feature macro: R5P_DEGU_IFQ_RVC_EN
//   defined   : 16-bit (compressed) instructions and halfword-aligned
//               extraction, including 32-bit instructions that straddle a
//               word boundary.
//   undefined : every instruction is 32-bit and word aligned; each consumed
//               instruction pops exactly one word.
//
// Parameters:
//   ABW   : fetch address width
//   DEPTH : word FIFO depth (power of two, >= 2)
//   PC0   : reset fetch address (halfword aligned)
//
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   jmp_vld, jmp_adr   : redirect request and target (bit 0 ignored)
//   ins_vld, ins_rdy   : instruction handshake towards the core
//   ins_rdt            : instruction (upper half zero for 16-bit)
//   ins_adr            : instruction PC
//   ins_siz            : 0 = 16-bit, 1 = 32-bit
//   ins_err            : bus error on any word the instruction uses
//   mem_vld, mem_rdy   : fetch request handshake
//   mem_adr            : fetch address (word aligned)
//   mem_rdt, mem_err   : read data and bus error, one cycle after a transfer

module r5p_degu_ifq #(
  parameter int unsigned     ABW   = 32,
  parameter int unsigned     DEPTH = 2,
  parameter logic [ABW-1:0]  PC0   = '0
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           jmp_vld,
  input  logic [ABW-1:0] jmp_adr,
  output logic           ins_vld,
  input  logic           ins_rdy,
  output logic [31:0]    ins_rdt,
  output logic [ABW-1:0] ins_adr,
  output logic           ins_siz,
  output logic           ins_err,
  output logic           mem_vld,
  output logic [ABW-1:0] mem_adr,
  input  logic           mem_rdy,
  input  logic [31:0]    mem_rdt,
  input  logic           mem_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  localparam logic [ABW-1:0] FADR_RST = {PC0[ABW-1:2], 2'b00};
`ifdef R5P_DEGU_IFQ_RVC_EN
  localparam logic [ABW-1:0] PC_RST  = {PC0[ABW-1:1], 1'b0};
  localparam logic           OFS_RST = PC0[1];
`else
  localparam logic [ABW-1:0] PC_RST  = FADR_RST;
  localparam logic           OFS_RST = 1'b0;
`endif

  // state
  logic           run;     // fetching enabled (set one cycle after reset)
  logic           rsp;     // a transfer last cycle whose response is kept
  logic [CW-1:0]  cnt;     // FIFO occupancy in words
  logic [AW-1:0]  rptr;
  logic [AW-1:0]  wptr;
  logic [32:0]    fifo [DEPTH];  // {err, data}
  logic [ABW-1:0] pc;
  logic [ABW-1:0] fadr;
  logic           ofs;     // halfword offset of the PC inside the head word

  // combinational helpers
  logic [CW:0]    occ;
  logic           xfer;
  logic           push;
  logic           consume;
  logic           pop;
  logic           pop_one;
  logic           ofs_nxt;
  logic [ABW-1:0] jmp_pc;
  logic           jmp_ofs;
  logic [32:0]    head;

  assign head = fifo[rptr];

  // Responses already on their way count against the FIFO space, so a
  // request is only issued when its data is guaranteed a slot.
  assign occ     = {1'b0, cnt} + {{CW{1'b0}}, rsp};
  assign mem_vld = run & (occ < DEPTH_W);
  assign mem_adr = fadr;
  assign xfer    = mem_vld & mem_rdy;
  assign push    = rsp & ~jmp_vld;

  assign ins_adr = pc;
  assign consume = ins_vld & ins_rdy & ~jmp_vld;
  assign pop     = consume & pop_one;

`ifdef R5P_DEGU_IFQ_RVC_EN
  logic [32:0] nxt;
  logic [15:0] hw;
  logic        unused_bits;

  assign nxt         = fifo[rptr + AW'(1)];
  assign jmp_pc      = {jmp_adr[ABW-1:1], 1'b0};
  assign jmp_ofs     = jmp_adr[1];
  assign unused_bits = jmp_adr[0];
`else
  logic unused_bits;

  assign jmp_pc      = {jmp_adr[ABW-1:2], 2'b00};
  assign jmp_ofs     = 1'b0;
  assign unused_bits = ^{jmp_adr[1:0], ofs};
`endif

  // Instruction extraction from the head word (and the next word for a
  // straddling 32-bit instruction).
  // NOTE: every output of this block gets a default first, so no path
  // through it leaves a variable unassigned and no latch is inferred.
  always_comb begin
    ins_vld = 1'b0;
    ins_rdt = head[31:0];
    ins_siz = 1'b1;
    ins_err = head[32];
    pop_one = 1'b1;
    ofs_nxt = 1'b0;
`ifdef R5P_DEGU_IFQ_RVC_EN
    hw      = ofs ? head[31:16] : head[15:0];
    ins_siz = &hw[1:0];
    // 16-bit at ofs=0 stays in the same word; everything else leaves it.
    pop_one = ofs | ins_siz;
    // 16-bit toggles the halfword offset, 32-bit keeps it.
    ofs_nxt = ofs ^ ~ins_siz;
    if (!ins_siz) begin
      ins_rdt = {16'h0000, hw};
      ins_vld = (cnt != '0);
    end else if (!ofs) begin
      ins_vld = (cnt != '0);
    end else begin
      // straddling: low half from the head word, high half from the next
      ins_rdt = {nxt[15:0], head[31:16]};
      ins_err = head[32] | nxt[32];
      ins_vld = (cnt >= CW'(2));
    end
`else
    ins_vld = (cnt != '0);
`endif
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run  <= 1'b0;
      rsp  <= 1'b0;
      cnt  <= '0;
      rptr <= '0;
      wptr <= '0;
      pc   <= PC_RST;
      fadr <= FADR_RST;
      ofs  <= OFS_RST;
      // NOTE: the FIFO storage is reset too; it is tiny and this keeps the
      // combinational instruction outputs at zero while in reset.
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else begin
      run <= 1'b1;
      // a transfer in the redirect cycle belongs to the old stream
      rsp <= xfer & ~jmp_vld;
      if (jmp_vld) begin
        cnt  <= '0;
        rptr <= '0;
        wptr <= '0;
        pc   <= jmp_pc;
        ofs  <= jmp_ofs;
        fadr <= jmp_pc & ~ABW'(3);
      end else begin
        if (xfer) fadr <= fadr + ABW'(4);
        if (push) begin
          fifo[wptr] <= {mem_err, mem_rdt};
          wptr       <= wptr + AW'(1);
        end
        if (pop) rptr <= rptr + AW'(1);
        unique case ({push, pop})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
        if (consume) begin
          pc  <= pc + (ins_siz ? ABW'(4) : ABW'(2));
          ofs <= ofs_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_r5p_degu_ifq.sv
// Directed testbench for r5p_degu_ifq (PC0 = 0x100, DEPTH = 2).
// A small word image answers fetches one cycle after each transfer; cycles
// without a kept transfer drive garbage data with the error flag set.
// Sections depending on R5P_DEGU_IFQ_RVC_EN follow the build of the design.

module tb_r5p_degu_ifq;

  logic        clk = 1'b0;
  logic        rst;
  logic        jmp_vld;
  logic [31:0] jmp_adr;
  logic        ins_vld;
  logic        ins_rdy;
  logic [31:0] ins_rdt;
  logic [31:0] ins_adr;
  logic        ins_siz;
  logic        ins_err;
  logic        mem_vld;
  logic [31:0] mem_adr;
  logic        mem_rdy;
  logic [31:0] mem_rdt;
  logic        mem_err;

  logic [31:0] img [0:255];
  logic        err_on;
  logic [31:0] err_adr;

  int n_tests = 0;
  int n_fail  = 0;

  r5p_degu_ifq #(
    .ABW   (32),
    .DEPTH (2),
    .PC0   (32'h0000_0100)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .jmp_vld (jmp_vld),
    .jmp_adr (jmp_adr),
    .ins_vld (ins_vld),
    .ins_rdy (ins_rdy),
    .ins_rdt (ins_rdt),
    .ins_adr (ins_adr),
    .ins_siz (ins_siz),
    .ins_err (ins_err),
    .mem_vld (mem_vld),
    .mem_adr (mem_adr),
    .mem_rdy (mem_rdy),
    .mem_rdt (mem_rdt),
    .mem_err (mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of test, expected end within 1 ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle; the bus model answers a kept transfer on the next cycle.
  task automatic tick();
    logic        x;
    logic [31:0] a;
    @(negedge clk);
    x = mem_vld & mem_rdy & ~jmp_vld & ~rst;
    a = mem_adr;
    @(posedge clk);
    #1;
    if (x) begin
      mem_rdt = img[a[9:2]];
      mem_err = err_on && (a == err_adr);
    end else begin
      mem_rdt = 32'hdead_beef;
      mem_err = 1'b1;
    end
  endtask

  task automatic jump(input logic [31:0] adr);
    jmp_vld = 1'b1;
    jmp_adr = adr;
    ins_rdy = 1'b1;  // must be ignored during a redirect
    tick();
    jmp_vld = 1'b0;
    ins_rdy = 1'b0;
  endtask

  // Wait (bounded) for an instruction, check it, then consume it.
  task automatic take(input string tag, input logic [31:0] adr, input logic [31:0] rdt,
                      input logic siz, input logic err);
    int n;
    n = 0;
    while (ins_vld !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, " vld"}, 64'(ins_vld), 64'd1);
    check({tag, " adr"}, 64'(ins_adr), 64'(adr));
    check({tag, " rdt"}, 64'(ins_rdt), 64'(rdt));
    check({tag, " siz"}, 64'(ins_siz), 64'(siz));
    check({tag, " err"}, 64'(ins_err), 64'(err));
    ins_rdy = 1'b1;
    tick();
    ins_rdy = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) img[k] = 32'h0000_0013 | (32'(k) << 16);
    err_on  = 1'b0;
    err_adr = 32'h0;
    rst     = 1'b1;
    jmp_vld = 1'b0;
    jmp_adr = 32'h0;
    ins_rdy = 1'b0;
    mem_rdy = 1'b1;
    mem_rdt = 32'h0;
    mem_err = 1'b0;

    // ---- reset state
    tick();
    tick();
    check("rst mem_vld", 64'(mem_vld), 64'd0);
    check("rst ins_vld", 64'(ins_vld), 64'd0);
    check("rst ins_rdt", 64'(ins_rdt), 64'd0);
    check("rst ins_adr", 64'(ins_adr), 64'h100);
    check("rst ins_err", 64'(ins_err), 64'd0);
`ifdef R5P_DEGU_IFQ_RVC_EN
    check("rst ins_siz", 64'(ins_siz), 64'd0);
`endif

    // ---- release: run, first fetch, no bypass, occupancy limit
    rst = 1'b0;
    tick();
    check("rel mem_vld", 64'(mem_vld), 64'd1);
    check("rel mem_adr", 64'(mem_adr), 64'h100);
    check("rel ins_vld", 64'(ins_vld), 64'd0);
    tick();  // transfer 0x100
    check("f1 ins_vld nobypass", 64'(ins_vld), 64'd0);
    check("f1 mem_vld", 64'(mem_vld), 64'd1);
    check("f1 mem_adr", 64'(mem_adr), 64'h104);
    tick();  // push 0x100, transfer 0x104
    check("f2 ins_vld", 64'(ins_vld), 64'd1);
    check("f2 mem_vld full", 64'(mem_vld), 64'd0);
    take("s0", 32'h100, 32'h0040_0013, 1'b1, 1'b0);
    take("s1", 32'h104, 32'h0041_0013, 1'b1, 1'b0);
    take("s2", 32'h108, 32'h0042_0013, 1'b1, 1'b0);
    take("s3", 32'h10c, 32'h0043_0013, 1'b1, 1'b0);

    // ---- address wrap
    jump(32'hffff_fffc);
    check("wrap mem_adr", 64'(mem_adr), 64'hffff_fffc);
    check("wrap ins_vld", 64'(ins_vld), 64'd0);
    take("w0", 32'hffff_fffc, 32'h00ff_0013, 1'b1, 1'b0);
    take("w1", 32'h0000_0000, 32'h0000_0013, 1'b1, 1'b0);

`ifndef R5P_DEGU_IFQ_RVC_EN
    // ---- halfword target is word aligned without compressed support
    jump(32'h102);
    check("j102 mem_adr", 64'(mem_adr), 64'h100);
    check("j102 ins_adr", 64'(ins_adr), 64'h100);
    check("j102 ins_vld", 64'(ins_vld), 64'd0);
    tick();
    check("j102 nobypass", 64'(ins_vld), 64'd0);
    take("j0", 32'h100, 32'h0040_0013, 1'b1, 1'b0);
    take("j1", 32'h104, 32'h0041_0013, 1'b1, 1'b0);
`endif

    // ---- bus stall, then core stall
    mem_rdy = 1'b0;
    jump(32'h200);
    for (int i = 0; i < 5; i++) begin
      check("stall mem_vld", 64'(mem_vld), 64'd1);
      check("stall mem_adr", 64'(mem_adr), 64'h200);
      tick();
    end
    check("stall ins_vld", 64'(ins_vld), 64'd0);
    mem_rdy = 1'b1;
    tick();  // transfer 0x200
    check("cs mem_adr", 64'(mem_adr), 64'h204);
    tick();  // push 0x200, transfer 0x204
    check("cs ins_vld", 64'(ins_vld), 64'd1);
    check("cs mem_vld inflight", 64'(mem_vld), 64'd0);
    tick();  // push 0x204, FIFO full
    check("cs mem_vld full", 64'(mem_vld), 64'd0);
    check("cs mem_adr hold", 64'(mem_adr), 64'h208);
    mem_rdy = 1'b0;
    take("c0", 32'h200, 32'h0080_0013, 1'b1, 1'b0);
    take("c1", 32'h204, 32'h0081_0013, 1'b1, 1'b0);
    check("drain ins_vld", 64'(ins_vld), 64'd0);
    check("drain mem_vld", 64'(mem_vld), 64'd1);
    check("drain mem_adr", 64'(mem_adr), 64'h208);
    mem_rdy = 1'b1;

    // ---- bus error marks only instructions using the faulty word
    err_on  = 1'b1;
    err_adr = 32'h8;
`ifdef R5P_DEGU_IFQ_RVC_EN
    img[1] = 32'h0013_0001;
    img[2] = 32'h0001_0000;
    jump(32'h4);
    take("e0", 32'h4, 32'h0000_0001, 1'b0, 1'b0);
    take("e1", 32'h6, 32'h0000_0013, 1'b1, 1'b1);
`else
    jump(32'h4);
    take("e0", 32'h4, 32'h0001_0013, 1'b1, 1'b0);
    take("e1", 32'h8, 32'h0002_0013, 1'b1, 1'b1);
    take("e2", 32'hc, 32'h0003_0013, 1'b1, 1'b0);
`endif
    err_on = 1'b0;

`ifdef R5P_DEGU_IFQ_RVC_EN
    // ---- mixed stream: straddling 32-bit needs two words
    img[0]  = 32'h0013_4501;
    img[1]  = 32'h0000_0513;
    mem_rdy = 1'b0;
    jump(32'h0);
    mem_rdy = 1'b1;
    tick();  // transfer 0x0
    mem_rdy = 1'b0;
    tick();  // push word 0x0
    check("rvc ins_vld", 64'(ins_vld), 64'd1);
    take("r0", 32'h0, 32'h0000_4501, 1'b0, 1'b0);
    check("rvc straddle wait", 64'(ins_vld), 64'd0);
    check("rvc straddle adr", 64'(ins_adr), 64'h2);
    mem_rdy = 1'b1;
    take("r1", 32'h2, 32'h0513_0013, 1'b1, 1'b0);

    // ---- redirect with a pending request and a response in flight
    jump(32'h300);
    tick();  // transfer 0x300, its response arrives in the redirect cycle
    mem_rdy = 1'b0;
    img[8'h81] = 32'h4505_0001;
    jump(32'h206);
    check("j206 ins_vld", 64'(ins_vld), 64'd0);
    check("j206 mem_vld", 64'(mem_vld), 64'd1);
    check("j206 mem_adr", 64'(mem_adr), 64'h204);
    check("j206 ins_adr", 64'(ins_adr), 64'h206);
    mem_rdy = 1'b1;
    take("h0", 32'h206, 32'h0000_4505, 1'b0, 1'b0);
    take("h1", 32'h208, 32'h0082_0013, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
